// File: rtl/kamikaze_mem_arbiter_pkg.sv
// Shared types and constants for the kamikaze memory arbiter: response owner
// encoding, full-word byte-enable and the default memory word-address width.
package kamikaze_pkg;

  localparam int DEFAULT_ADDR_W = 14;

  localparam logic [3:0] BE_WORD = 4'hF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/kamikaze_mem_arbiter_if.sv
// Bus bundle between fetch, load/store unit, arbiter and tightly coupled memory.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
interface kamikaze_mem_arbiter_if
  import kamikaze_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [3:0]        dm_be_i;
  logic [31:0]       dm_addr_i;
  logic [31:0]       dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [31:0]       dm_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requester and memory side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/kamikaze_mem_arbiter.sv
// Single-port memory arbiter: DM has priority over IF, responses return one cycle
// after grant. Optional IF anti-starvation guard: KAMIKAZE_ARB_STARVE_GUARD_EN.
module kamikaze_mem_arbiter
  import kamikaze_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  kamikaze_mem_arbiter_if.slave  bus
);

  owner_e      owner_q, owner_d;
  logic [31:0] ifHold_q, ifHold_d;
  logic        ifGnt, dmGnt, forceIf;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^{bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0],
                            bus.dm_addr_i[31:ADDR_W+2], bus.dm_addr_i[1:0]};

`ifdef KAMIKAZE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

  assign forceIf = (starveCnt_q == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) starveCnt_q <= '0;
    else       starveCnt_q <= starveCnt_d;
  end

  // Counts only cycles where IF is actually waiting behind DM; saturates at the limit
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!bus.if_req_i || ifGnt)
      starveCnt_d = '0;
    else if (dmGnt && !forceIf)
      starveCnt_d = starveCnt_q + CNT_W'(1);
  end
`else
  localparam int unusedStarveMax = STARVE_MAX;

  assign forceIf = 1'b0;
`endif

  // Grants are suppressed during reset so a store in the reset cycle never lands
  always_comb begin
    dmGnt = 1'b0;
    ifGnt = 1'b0;
    if (!rst_i) begin
      dmGnt = bus.dm_req_i && !(bus.if_req_i && forceIf);
      ifGnt = bus.if_req_i && !dmGnt;
    end
  end

  always_comb begin
    bus.if_gnt_o    = ifGnt;
    bus.dm_gnt_o    = dmGnt;
    bus.mem_en_o    = ifGnt || dmGnt;
    bus.mem_we_o    = dmGnt && bus.dm_we_i;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = 32'h0;
    if (dmGnt) begin
      bus.mem_be_o    = bus.dm_be_i;
      bus.mem_addr_o  = bus.dm_addr_i[ADDR_W+1:2];
      bus.mem_wdata_o = bus.dm_wdata_i;
    end else if (ifGnt) begin
      bus.mem_be_o   = BE_WORD;
      bus.mem_addr_o = bus.if_addr_i[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) owner_q <= OWN_NONE;
    else       owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (ifGnt)
      owner_d = OWN_IF;
    else if (dmGnt && !bus.dm_we_i)
      owner_d = OWN_DM;
  end

  // Responses in flight at reset are dropped by qualifying rvalid with rst_i
  always_comb begin
    bus.if_rvalid_o = (owner_q == OWN_IF) && !rst_i;
    bus.dm_rvalid_o = (owner_q == OWN_DM) && !rst_i;
    bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_rdata_i : 32'h0;
    if (bus.if_rvalid_o)
      bus.if_rdata_o = bus.mem_rdata_i;
    else if (rst_i)
      bus.if_rdata_o = 32'h0;
    else
      bus.if_rdata_o = ifHold_q;
  end

  assign ifHold_d = bus.if_rvalid_o ? bus.mem_rdata_i : ifHold_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ifHold_q <= 32'h0;
    else       ifHold_q <= ifHold_d;
  end

endmodule

// File: doc/kamikaze_mem_arbiter.md
Name: kamikaze_mem_arbiter

Overview:
- Shares one single-port, synchronous-read memory between instruction fetch (IF) and the load/store unit (DM).
- Sits between kamikaze_fetch and the tightly coupled memory.
- Grants one requester per cycle and routes the 1-cycle-late read data back to whichever requester owns it.
- Holds the last fetch word stable while fetch is not granted, so the fetch stage sees clean data while stalled.

Parameters:
- ADDR_W, 14, memory word-address width (memory depth = 2^ADDR_W words)
- STARVE_MAX, 4, consecutive lost IF cycles before IF is forced to win (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch byte address; bits [1:0] ignored
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data; held between responses
- dm_req_i  in  1  load/store request
- dm_we_i  in  1  1 = store
- dm_be_i  in  4  store byte enables
- dm_addr_i  in  32  load/store byte address; bits [1:0] ignored
- dm_wdata_i  in  32  store data
- dm_gnt_o  out  1  load/store accepted this cycle
- dm_rvalid_o  out  1  load data valid
- dm_rdata_o  out  32  load data; valid only while dm_rvalid_o=1
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  ADDR_W  memory word address = granted addr[ADDR_W+1:2]
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid the cycle after a read strobe

Behaviour:
- **Clock and reset:** one clock, clk_i. Reset rst_i is synchronous and active-high.
- **Request handshake:**
  - A requester holds req and its payload stable until it sees gnt.
  - gnt is combinational from req and state; at most one gnt per cycle.
  - The request is consumed on the cycle gnt=1.
- **Priority:** DM beats IF when both request. A lone request is granted in the same cycle. No request → mem_en_o=0; mem_addr/be/wdata are don't-care and are driven 0.
- **Memory drive:**
  - mem_en_o = if_gnt_o | dm_gnt_o.
  - mem_we_o = dm_gnt_o & dm_we_i, and is never 1 on an IF grant.
  - mem_be_o = dm_be_i for DM grants, 4'hF for IF grants.
- **Response tracking:** owner register with states NONE / IF / DM, loaded each cycle:
  - IF if if_gnt_o.
  - DM if dm_gnt_o & !dm_we_i.
  - NONE otherwise; stores produce no response.
- **Read responses (latency exactly 1 cycle from grant):**
  - owner=IF → if_rvalid_o=1 and if_rdata_o=mem_rdata_i (combinational bypass). The word is also captured into a hold register.
  - owner=DM → dm_rvalid_o=1 and dm_rdata_o=mem_rdata_i.
  - if_rdata_o outside an IF response = hold register. This keeps it unchanged across DM-stolen cycles and IF idle cycles.
- **Back-to-back:** the IF and DM pipelines are fully pipelined. A grant is allowed in the same cycle as the previous grant's response.
- **Reset values:**
  - owner=NONE, hold register=32'h0.
  - All gnt/rvalid outputs = 0, so no response is issued the cycle after reset.
  - if_rdata_o=0, dm_rdata_o=0.
- **Reset mid-operation:** an outstanding response is dropped and no rvalid fires the following cycle. A store granted in the same cycle as rst_i is not written (mem_en_o forced 0 during reset).
- **Unaligned addresses:** not flagged; low bits are dropped silently. Fetch realignment is the fetch stage's job.

Optional Feature:
- Macro: KAMIKAZE_ARB_STARVE_GUARD_EN.
- **With the macro defined:**
  - A saturating counter of width $clog2(STARVE_MAX+1) increments each cycle IF requests and loses to DM.
  - The counter clears to 0 on IF grant, when if_req_i=0, and on reset.
  - When count==STARVE_MAX, IF wins the next contested cycle. dm_gnt_o=0 that cycle; DM keeps its request held.
- **Without the macro:** strict DM priority; IF can starve indefinitely; no counter logic.

Decomposition:
- kamikaze_pkg holds:
  - the owner enum (OWN_NONE=0, OWN_IF=1, OWN_DM=2)
  - the byte-enable constant BE_WORD=4'hF
  - the default ADDR_W
- No sub-module. The starvation counter stays inline under the macro; the block is a single module.

Test Plan:
- IF-only reads:
  - Stimulus: if_req_i=1 at addr 0x0, 0x4, 0x8 on consecutive cycles.
  - Required: if_gnt_o=1 every cycle; mem_addr_o=0,1,2; if_rvalid_o=1 one cycle later carrying the memory words in order.
- Contention:
  - Stimulus: both request; DM loads from 0x100.
  - Required: dm_gnt_o=1, if_gnt_o=0, mem_addr_o=0x40. The next cycle dm_rvalid_o=1, if_rvalid_o=0, and if_rdata_o still equals the previous fetch word.
- Store with byte enables:
  - Stimulus: dm_we_i=1, be=4'b0011, addr 0x20, wdata 0xDEADBEEF, then an IF read of 0x20.
  - Required: mem_we_o=1 with mem_be_o=4'b0011; no dm_rvalid_o; the fetch returns the low half updated to 0xBEEF.
- Reset mid-read:
  - Stimulus: IF granted at cycle N, rst_i=1 at cycle N+1.
  - Required: if_rvalid_o=0 at N+1 and N+2; if_rdata_o=0 after reset.
- Starvation (macro on, STARVE_MAX=4):
  - Stimulus: DM and IF both request continuously.
  - Required: DM granted 4 cycles, then IF granted on the 5th, then the pattern repeats. With the macro off, IF is never granted over 20 cycles.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: mem_en_o=0, all rvalid=0, if_rdata_o constant.
